// File: rtl/seq_scan_arbiter_if.sv
// Request/report bundle between the requesting engines and the shared 1011 scanner.
// master = requester side, slave = scanner side.
interface seq_scan_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]              req;
    logic [NREQ*WIDTH-1:0]        data;
    logic [NREQ-1:0]              gnt;
    logic                         busy;
    logic                         hit;
    logic                         done;
    logic [$clog2(NREQ)-1:0]      done_id;
    logic [$clog2(WIDTH+1)-1:0]   match_cnt;

    modport master (
        output req, data,
        input  gnt, busy, hit, done, done_id, match_cnt
    );

    modport slave (
        input  req, data,
        output gnt, busy, hit, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding one time-shared Moore 1011 detector, MSB-first per word.
// Define SEQ_SCAN_OVERLAP_EN for overlapping matches; the default build is non-overlapping.
module seq_scan_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_scan_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH+1);
    localparam int BW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_REPORT
    } state_t;

    typedef enum logic [2:0] {
        D_S0,
        D_S1,
        D_S2,
        D_S3,
        D_S4
    } det_t;

    state_t             r_state;
    det_t               r_det;
    logic [WIDTH-1:0]   r_shift;
    logic [BW-1:0]      r_cnt;
    logic [CW-1:0]      r_match;
    logic [IDW-1:0]     r_last;
    logic [IDW-1:0]     r_done_id;
    logic [NREQ-1:0]    r_gnt;
    logic               r_busy;
    logic               r_hit;
    logic               r_done;

    logic [WIDTH-1:0]   w_words [NREQ];
    logic [IDW-1:0]     w_win;
    logic               w_any;
    det_t               w_det_next;
    logic               w_bit;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_words[gi] = bus.data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_any = |bus.req;
    assign w_bit = r_shift[WIDTH-1];

    // Scan from farthest to nearest so the requester closest after r_last wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_win = r_last;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = int'(r_last) + 1 + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[idx[IDW-1:0]]) w_win = idx[IDW-1:0];
        end
    end

    always_comb begin
        w_det_next = D_S0;
        case (r_det)
            D_S0: w_det_next = w_bit ? D_S1 : D_S0;
            D_S1: w_det_next = w_bit ? D_S1 : D_S2;
            D_S2: w_det_next = w_bit ? D_S3 : D_S0;
            D_S3: w_det_next = w_bit ? D_S4 : D_S2;
            D_S4: begin
`ifdef SEQ_SCAN_OVERLAP_EN
                w_det_next = w_bit ? D_S1 : D_S2;
`else
                w_det_next = w_bit ? D_S1 : D_S0;
`endif
            end
            default: w_det_next = D_S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_det     <= D_S0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_match   <= '0;
            r_last    <= IDW'(NREQ-1);
            r_done_id <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_hit     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_shift <= w_words[w_win];
                        r_cnt   <= BW'(WIDTH-1);
                        r_match <= '0;
                        r_det   <= D_S0;
                        r_hit   <= 1'b0;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_det   <= w_det_next;
                    r_hit   <= (w_det_next == D_S4);
                    if ((w_det_next == D_S4) && (r_match != {CW{1'b1}})) begin
                        r_match <= r_match + 1'b1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    // Counter at zero means this edge consumes the last bit.
                    if (r_cnt == '0) begin
                        r_state   <= ST_REPORT;
                        r_done    <= 1'b1;
                        r_done_id <= r_last;
                    end
                end
                ST_REPORT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.busy      = r_busy;
    assign bus.hit       = r_hit;
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match;
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: an 8-bit/4-requester instance and a 16-bit/2-requester instance.
// Expected counts follow SEQ_SCAN_OVERLAP_EN when it is defined.
module tb_seq_scan_arbiter;
    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEQ_SCAN_OVERLAP_EN
    localparam int EXP_T1 = 2;
`else
    localparam int EXP_T1 = 1;
`endif

    seq_scan_arbiter_if #(.NREQ(4), .WIDTH(8))  bus ();
    seq_scan_arbiter_if #(.NREQ(2), .WIDTH(16)) bus16 ();

    seq_scan_arbiter #(.NREQ(4), .WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    seq_scan_arbiter #(.NREQ(2), .WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Steps until done (bounded); reports cycles taken, hit-high cycles and stray grants.
    task automatic run_word(output int cycles, output int hits, output int gnts);
        cycles = 0;
        hits   = 0;
        gnts   = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cycles++;
            if (bus.hit) hits++;
            if (bus.gnt != '0) gnts++;
            if (bus.done) break;
        end
    endtask

    initial begin
        int cyc, hits, gnts, ng, nd, prev;

        reset      = 1'b1;
        bus.req    = '0;
        bus.data   = '0;
        bus16.req  = '0;
        bus16.data = '0;
        tick();
        tick();
        check("rst_gnt",    32'(bus.gnt), 0);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_hit",    32'(bus.hit), 0);
        check("rst_done",   32'(bus.done), 0);
        check("rst_id",     32'(bus.done_id), 0);
        check("rst_cnt",    32'(bus.match_cnt), 0);
        check("rst16_busy", 32'(bus16.busy), 0);
        reset = 1'b0;
        tick();

        // Single word 1011_0110 from requester 0.
        bus.data[7:0] = 8'b1011_0110;
        bus.req       = 4'b0001;
        tick();
        check("t1_gnt",  32'(bus.gnt), 32'h1);
        check("t1_busy", 32'(bus.busy), 1);
        bus.req = '0;
        run_word(cyc, hits, gnts);
        check("t1_lat",   32'(cyc), 8);
        check("t1_id",    32'(bus.done_id), 0);
        check("t1_cnt",   32'(bus.match_cnt), 32'(EXP_T1));
        check("t1_hits",  32'(hits), 32'(EXP_T1));
        check("t1_gnt1x", 32'(gnts), 0);
        tick();
        check("t1_done0", 32'(bus.done), 0);
        check("t1_busy0", 32'(bus.busy), 0);
        check("t1_hold",  32'(bus.match_cnt), 32'(EXP_T1));

        // All requesters continuously, all-ones words: rotation from 0 after reset.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        bus.data = {4{8'hFF}};
        bus.req  = 4'b1111;
        ng = 0; nd = 0; prev = 0; hits = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (bus.gnt != '0) begin
                check("rr_gnt", 32'(bus.gnt), 32'(1) << (ng % 4));
                if (ng > 0) check("rr_space", 32'(c - prev), 10);
                prev = c;
                ng++;
            end
            if (bus.done) begin
                check("rr_id",  32'(bus.done_id), 32'(nd % 4));
                check("rr_cnt", 32'(bus.match_cnt), 0);
                nd++;
            end
            if (bus.hit) hits++;
        end
        check("rr_ngnt", 32'(ng), 5);
        check("rr_ndone", 32'(nd), 4);
        check("rr_hits", 32'(hits), 0);
        bus.req = '0;
        run_word(cyc, hits, gnts);
        check("rr_last_id", 32'(bus.done_id), 0);
        tick();

        // 1011_1011 on requester 2 alone: two matches in either mode, ends in S4.
        bus.data[23:16] = 8'b1011_1011;
        bus.req         = 4'b0100;
        tick();
        check("t3_gnt", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        run_word(cyc, hits, gnts);
        check("t3_lat",  32'(cyc), 8);
        check("t3_id",   32'(bus.done_id), 2);
        check("t3_cnt",  32'(bus.match_cnt), 2);
        check("t3_hits", 32'(hits), 2);
        check("t3_hit",  32'(bus.hit), 1);
        tick();

        // Abort a word with reset after hit has risen.
        bus.data[7:0] = 8'b1011_0000;
        bus.req       = 4'b0001;
        tick();
        check("t4_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        for (int c = 0; c < 4; c++) tick();
        check("t4_prehit", 32'(bus.hit), 1);
        reset = 1'b1;
        #1;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_hit",  32'(bus.hit), 0);
        check("t4_done", 32'(bus.done), 0);
        check("t4_gnt0", 32'(bus.gnt), 0);
        check("t4_id",   32'(bus.done_id), 0);
        check("t4_cnt",  32'(bus.match_cnt), 0);
        tick();
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done) nd++;
        end
        check("t4_nodone", 32'(nd), 0);

        // Requesters 1 and 3 pending: 1 first; 3 held through SHIFT and granted after REPORT.
        bus.data[15:8]  = 8'b0000_1011;
        bus.data[31:24] = 8'b1011_0000;
        bus.req         = 4'b1010;
        tick();
        check("t5_gnt1", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1000;
        run_word(cyc, hits, gnts);
        check("t5_lat",    32'(cyc), 8);
        check("t5_id1",    32'(bus.done_id), 1);
        check("t5_cnt1",   32'(bus.match_cnt), 1);
        check("t5_nogntx", 32'(gnts), 0);
        tick();
        check("t5_idle",  32'(bus.gnt), 0);
        tick();
        check("t5_gnt3", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        run_word(cyc, hits, gnts);
        check("t5_id3",  32'(bus.done_id), 3);
        check("t5_cnt3", 32'(bus.match_cnt), 1);
        tick();

        // 16-bit word 1011 repeated four times.
        bus16.data[15:0] = 16'b1011_1011_1011_1011;
        bus16.req        = 2'b01;
        tick();
        check("w16_gnt", 32'(bus16.gnt), 32'h1);
        bus16.req = '0;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cyc++;
            if (bus16.done) break;
        end
        check("w16_lat", 32'(cyc), 16);
        check("w16_id",  32'(bus16.done_id), 0);
        check("w16_cnt", 32'(bus16.match_cnt), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
